// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: one shift-add or restoring shift-subtract step per cycle, done XLEN+1 cycles after accept (1 for div-by-zero/overflow).
// No backpressure: start is only taken while idle; busy stalls the pipeline, flush aborts without a done pulse.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            sel_lo_q, sel_lo_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] fin_q, fin_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode at accept time
    logic            signed_a, signed_b, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_val;

    // One iteration of the datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     shifted;
    logic              ge;
    logic [XLEN-1:0]   iter_acc, iter_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_val;

    always_comb begin
        signed_a = !(op == 3'b011 || op == 3'b101 || op == 3'b111);
        signed_b = (op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b110);
        sa       = signed_a && operand_a[XLEN-1];
        sb       = signed_b && operand_b[XLEN-1];
        mag_a    = sa ? (~operand_a + 1'b1) : operand_a;
        mag_b    = sb ? (~operand_b + 1'b1) : operand_b;

        div_zero = op[2] && (operand_b == '0);
        div_ovf  = (op == 3'b100 || op == 3'b110)
                   && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (operand_b == '1);
        if (div_zero)
            special_val = op[1] ? operand_a : '1;
        else
            special_val = op[1] ? '0 : operand_a;

        mul_sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
        // Partial remainder is XLEN+1 bits after the shift; a fitting trial result is always below the divisor
        shifted  = {acc_q, lo_q[XLEN-1]};
        ge       = shifted >= {1'b0, b_q};
        if (is_div_q) begin
            iter_acc = ge ? (shifted[XLEN-1:0] - b_q) : shifted[XLEN-1:0];
            iter_lo  = {lo_q[XLEN-2:0], ge};
        end else begin
            iter_acc = mul_sum[XLEN:1];
            iter_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        prod   = {iter_acc, iter_lo};
        prod_s = neg_q ? (~prod + 1'b1) : prod;
        quo_s  = neg_q ? (~iter_lo + 1'b1) : iter_lo;
        rem_s  = neg_q ? (~iter_acc + 1'b1) : iter_acc;
        if (is_div_q)
            final_val = sel_lo_q ? quo_s : rem_s;
        else
            final_val = sel_lo_q ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sel_lo_d = sel_lo_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        b_d      = b_q;
        fin_d    = fin_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    is_div_d = op[2];
                    sel_lo_d = op[2] ? !op[1] : (op[1:0] == 2'b00);
                    // Remainder follows the dividend's sign; everything else follows the product of signs
                    neg_d    = (op[2] && op[1]) ? sa : (sa ^ sb);
                    if (div_zero || div_ovf) begin
                        fin_d   = special_val;
                        state_d = FINISH;
                    end else begin
                        acc_d   = '0;
                        lo_d    = op[2] ? mag_a : mag_b;
                        b_d     = op[2] ? mag_b : mag_a;
                        cnt_d   = CW'(XLEN - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = iter_acc;
                    lo_d  = iter_lo;
                    if (cnt_q == '0) begin
                        fin_d   = final_val;
                        state_d = FINISH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (!flush)
                    result_d = fin_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sel_lo_q <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            fin_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sel_lo_q <= sel_lo_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            fin_q    <= fin_d;
            result_q <= result_d;
        end
    end

    // A flush landing in FINISH squashes the pulse and keeps the previous result visible
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FINISH) && !flush;
    assign result = done ? fin_q : result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer with a queue-based scoreboard checking result and accept-to-done latency.
module tb_muldiv_sequencer;

    localparam int NL = 32;  // posedges from accept edge to the done cycle, normal ops
    localparam int SL = 0;   // special cases: done in the cycle right after the accept edge

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        busy, done;
    logic [31:0] result;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int total = 0;
    int bad   = 0;

    always @(negedge clk) begin
        if (!reset && done) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done result=%h", result);
            end else begin
                e = sb_q.pop_front();
                if (result !== e.res) begin
                    bad++;
                    $display("FAIL %s result got=%h want=%h", e.name, result, e.res);
                end
                total++;
                if (cyc - e.t0 != e.lat) begin
                    bad++;
                    $display("FAIL %s latency got=%0d want=%0d", e.name, cyc - e.t0, e.lat);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Drives a start in the current cycle; caller is already away from the clock edge
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] r, input int lat, input bit push, input string nm);
        op = o; operand_a = x; operand_b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sb_q.push_back('{r, lat, cyc, nm});
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input int lat, input bit push, input string nm);
        @(negedge clk);
        launch(o, x, y, r, lat, push, nm);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout pending=%0d", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input int lat, input string nm);
        issue(o, x, y, r, lat, 1'b1, nm);
        drain();
    endtask

    initial begin
        int bc;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        op = 3'b000; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;

        // MUL with busy-window measurement
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, NL, 1'b1, "mul_7xm3");
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) bc++;
            else break;
        end
        chk("busy_cycles", bc, 32'd33);
        drain();

        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NL, "mulhu_ff");
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, NL, "mulh_ff");
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NL, "mulhsu_ff");
        run(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, NL, "mul_ff");
        run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NL, "mulh_min");
        run(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, NL, "mul_min");

        run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NL, "div_m7_2");
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NL, "rem_m7_2");
        run(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NL, "div_7_m2");
        run(3'b110, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, NL, "rem_7_m2");
        run(3'b111, 32'd100, 32'd7, 32'd2, NL, "remu_100_7");
        run(3'b100, 32'h8000_0000, 32'd2, 32'hC000_0000, NL, "div_min_2");
        run(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, NL, "divu_min_ff");
        run(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NL, "remu_min_ff");

        run(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, SL, "div_by0");
        run(3'b111, 32'd5, 32'd0, 32'd5, SL, "remu_by0");
        run(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, SL, "divu_by0");
        run(3'b110, 32'd5, 32'd0, 32'd5, SL, "rem_by0");
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SL, "div_ovf");
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SL, "rem_ovf");
        run(3'b101, 32'd100, 32'd7, 32'd14, NL, "divu_100_7");

        // Flush ten cycles into a MUL, then restart immediately
        issue(3'b000, 32'h1234, 32'h5678, 32'd0, NL, 1'b0, "flushed");
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_done", {31'b0, done}, 32'd0);
        chk("flush_result", result, 32'd14);
        launch(3'b011, 32'h1234_5678, 32'h10, 32'h0000_0001, NL, 1'b1, "mulhu_after_flush");
        drain();

        // Stray start with different operands in the middle of CALC
        issue(3'b000, 32'd3, 32'd5, 32'd15, NL, 1'b1, "mul_stray");
        repeat (5) @(negedge clk);
        launch(3'b100, 32'd100, 32'd7, 32'd0, NL, 1'b0, "stray");
        drain();

        // Synchronous reset mid-CALC
        issue(3'b000, 32'd9, 32'd9, 32'd0, NL, 1'b0, "reset_victim");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midop_reset_busy", {31'b0, busy}, 32'd0);
        chk("midop_reset_done", {31'b0, done}, 32'd0);
        chk("midop_reset_result", result, 32'd0);
        reset = 1'b0;
        run(3'b101, 32'd100, 32'd7, 32'd14, NL, "divu_after_reset");

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
